// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
package ro_meas_pkg;

    // Measurement FSM states; encoding is visible on the status byte.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArm     = 2'd1,
        StMeasure = 2'd2
    } ro_state_e;

    // byte_sel readout codes
    localparam logic [1:0] SelByte0  = 2'd0;
    localparam logic [1:0] SelByte1  = 2'd1;
    localparam logic [1:0] SelByte2  = 2'd2;
    localparam logic [1:0] SelStatus = 2'd3;

    // Status byte layout: {overflow, busy, continuous, 3'b0, state[1:0]}
    localparam int unsigned StatusOvfBit   = 7;
    localparam int unsigned StatusBusyBit  = 6;
    localparam int unsigned StatusContBit  = 5;
    localparam int unsigned StatusStateLsb = 0;

    // Readout width: the result is read over at most three bytes.
    localparam int unsigned ReadoutW = 24;

    function automatic logic [7:0] status_byte(input logic       ovf,
                                               input logic       busy,
                                               input logic       cont,
                                               input logic [1:0] st);
        logic [7:0] b;
        b                       = '0;
        b[StatusOvfBit]         = ovf;
        b[StatusBusyBit]        = busy;
        b[StatusContBit]        = cont;
        b[StatusStateLsb +: 2]  = st;
        return b;
    endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Synchronizer chain for an asynchronous data input plus rising-edge detect.
module ro_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift the input through the chain; history holds the previous synced value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Chain and history registers, free running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts synchronized rising edges of ro_in over a 2^GATE_LOG2-cycle gate window.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned GATE_LOG2   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             ro_in,
    input  logic             start,
    input  logic             continuous,
    input  logic [1:0]       byte_sel,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       byte_out
);

    ro_state_e            state_q, state_d;
    logic [GATE_LOG2-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]     edge_q, edge_d;
    logic                 pend_q, pend_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic [7:0]           byte_q, byte_d;

    logic                 rise;
    logic [CNT_W-1:0]     edge_inc;
    logic                 pend_inc;
    logic [ReadoutW-1:0]  count_ext;

    ro_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ro_in),
        .rise     (rise)
    );

    // Saturating edge count including this cycle's rise; the last gate cycle uses it directly.
    always_comb begin
        edge_inc = edge_q;
        pend_inc = pend_q;
        if (rise) begin
            if (edge_q == '1) begin
                pend_inc = 1'b1;
            end else begin
                edge_inc = edge_q + CNT_W'(1);
            end
        end
    end

    // FSM next state, gate/edge counters and result capture.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        pend_d  = pend_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ena && (start || continuous)) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                gate_d  = '0;
                edge_d  = '0;
                pend_d  = 1'b0;
                state_d = ena ? StMeasure : StIdle;
            end
            StMeasure: begin
                if (!ena) begin
                    // Abort: partial count dropped, previous result kept.
                    state_d = StIdle;
                end else begin
                    gate_d = gate_q + GATE_LOG2'(1);
                    edge_d = edge_inc;
                    pend_d = pend_inc;
                    if (gate_q == '1) begin
                        count_d = edge_inc;
                        ovf_d   = pend_inc;
                        done_d  = 1'b1;
                        state_d = continuous ? StArm : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Zero-extend the result so bits at or above CNT_W read as 0.
    always_comb begin
        count_ext              = '0;
        count_ext[CNT_W-1:0]   = count_q;
    end

    // Readout mux, registered one cycle behind byte_sel.
    always_comb begin
        byte_d = '0;
        unique case (byte_sel)
            SelByte0:  byte_d = count_ext[7:0];
            SelByte1:  byte_d = count_ext[15:8];
            SelByte2:  byte_d = count_ext[23:16];
            SelStatus: byte_d = status_byte(ovf_q, busy, continuous, state_q);
            default:   byte_d = '0;
        endcase
    end

    // All state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gate_q  <= '0;
            edge_q  <= '0;
            pend_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            byte_q  <= byte_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign count    = count_q;
    assign byte_out = byte_q;

endmodule
